// File: rtl/TicSAT_pkg.sv
// Shared types for the TicSAT systolic array: array commands and skewer FSM states.
// Latency: n/a (types and a constant helper only).
// Backpressure: n/a.
package TicSAT_pkg;

  // Commands understood by the systolic array; the skewer's stream_en maps to CMD_STREAM.
  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_LOAD_W = 2'd1,
    CMD_STREAM = 2'd2,
    CMD_CLEAR  = 2'd3
  } command_t;

  typedef enum logic [1:0] {
    SKEW_IDLE   = 2'd0,
    SKEW_STREAM = 2'd1,
    SKEW_DRAIN  = 2'd2
  } skew_state_t;

  // Zero steps needed after the last vector: push the deepest row's data out, then
  // give the column pass and PE pipeline their extra steps.
  function automatic int skew_drain_steps(input int sa_size, input int skew, input int extra);
    return (sa_size - 1) * skew + extra;
  endfunction

endpackage

// File: rtl/sa_skew_delay_line.sv
// Enable-gated shift register delaying one array row by DEPTH stream steps (DEPTH=0 is a wire).
// Latency: DEPTH enabled cycles from din to dout.
// Backpressure: none internally; en low holds every stage.
module sa_skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one position per stream step; the tail is what the array sees on this step.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_input_skewer.sv
// Skews activation vectors into the systolic array rows and flushes the array with zeros after each tile.
// Latency: row k emits element k k*SKEW_PER_ROW stream steps after acceptance; row 0 is combinational.
// Backpressure: stall_i freezes all state and drops in_ready; no input is taken while draining.
// Optional build macro SA_SKEW_PERF_EN adds perf_steps / perf_stalls counters.
module sa_input_skewer
  import TicSAT_pkg::*;
#(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32,
  parameter int SKEW_PER_ROW    = 1,
  parameter int DRAIN_EXTRA     = 8
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] in_data,
  input  logic                                    in_last,
  input  logic                                    stall_i,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_inputs,
  output logic                                    stream_en,
  output logic                                    busy,
  output logic                                    tile_done
`ifdef SA_SKEW_PERF_EN
  ,
  output logic [31:0]                             perf_steps,
  output logic [31:0]                             perf_stalls
`endif
);

  localparam int DRAIN_STEPS = skew_drain_steps(SA_SIZE, SKEW_PER_ROW, DRAIN_EXTRA);
  localparam int CNT_W       = $clog2(DRAIN_STEPS + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_STEPS - 1);

  skew_state_t                             state;
  logic [CNT_W-1:0]                        drain_cnt;
  logic                                    draining;
  logic                                    accept;
  logic                                    step;
  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] shift_in;
  logic [ACTIVATION_SIZE-1:0]              row_out [SA_SIZE];

  // Reset is synchronous, so the handshake is gated by resetn to stay quiet during it.
  assign draining  = (state == SKEW_DRAIN);
  assign in_ready  = resetn & ~draining & ~stall_i;
  assign accept    = in_valid & in_ready;
  assign step      = accept | (resetn & draining & ~stall_i);
  assign stream_en = step;
  assign busy      = (state != SKEW_IDLE);

  // Steps without an accepted vector feed zeros, which is what flushes the lines and the array.
  assign shift_in = accept ? in_data : '0;

  assign row_out[0] = shift_in[0];

  generate
    for (genvar k = 1; k < SA_SIZE; k++) begin : g_row
      sa_skew_delay_line #(
        .DEPTH(k * SKEW_PER_ROW),
        .WIDTH(ACTIVATION_SIZE)
      ) u_line (
        .clk   (clk),
        .resetn(resetn),
        .en    (step),
        .din   (shift_in[k]),
        .dout  (row_out[k])
      );
    end
  endgenerate

  // Gather the per-row taps into the array-facing bus.
  always_comb begin
    sa_inputs = '0;
    for (int k = 0; k < SA_SIZE; k++) sa_inputs[k] = row_out[k];
  end

  // Tile sequencing: stream until the last vector, then count down the zero drain steps.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= SKEW_IDLE;
      drain_cnt <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        SKEW_IDLE, SKEW_STREAM: begin
          if (accept) begin
            if (in_last) begin
              state     <= SKEW_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state <= SKEW_STREAM;
            end
          end
        end
        SKEW_DRAIN: begin
          if (step) begin
            if (drain_cnt == '0) begin
              state     <= SKEW_IDLE;
              tile_done <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        default: state <= SKEW_IDLE;
      endcase
    end
  end

`ifdef SA_SKEW_PERF_EN
  // Free-running step and stall counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_steps  <= '0;
      perf_stalls <= '0;
    end else begin
      if (step) perf_steps <= perf_steps + 32'd1;
      if (busy && stall_i) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_input_skewer.sv
// Randomized and directed bench for sa_input_skewer against a step-history reference model.
// Latency: n/a.
// Backpressure: exercised through stall_i and in_valid gaps.
module tb_sa_input_skewer;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int SKEW = 1;
  localparam int DX   = 4;
  localparam int DS   = (N - 1) * SKEW + DX;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][W-1:0]   in_data;
  logic                  in_last;
  logic                  stall_i;
  logic [N-1:0][W-1:0]   sa_inputs;
  logic                  stream_en;
  logic                  busy;
  logic                  tile_done;
`ifdef SA_SKEW_PERF_EN
  logic [31:0]           perf_steps;
  logic [31:0]           perf_stalls;
`endif

  always #5 clk = ~clk;

  sa_input_skewer #(
    .SA_SIZE        (N),
    .ACTIVATION_SIZE(W),
    .SKEW_PER_ROW   (SKEW),
    .DRAIN_EXTRA    (DX)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .stall_i    (stall_i),
    .sa_inputs  (sa_inputs),
    .stream_en  (stream_en),
    .busy       (busy),
    .tile_done  (tile_done)
`ifdef SA_SKEW_PERF_EN
    ,
    .perf_steps (perf_steps),
    .perf_stalls(perf_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the array sees, on row k at step n, element k of whatever entered at step n-k*SKEW
  // (zero for steps with no accepted vector, and for anything before reset).
  logic [N*W-1:0] hist [$];
  bit             m_tile;
  bit             m_drain;
  bit             m_done;
  int             m_left;
  bit             chk_en;
  int             stream_cnt;
  bit             obs_done;

  task automatic cyc(input bit rst_n, input bit v, input bit last, input bit st, input logic [N*W-1:0] d);
    bit             acc;
    bit             stp;
    logic [N*W-1:0] exp_rows;
    logic [N*W-1:0] old;
    logic [N*W-1:0] pushed;
    @(negedge clk);
    resetn   = rst_n;
    in_valid = v;
    in_last  = last;
    stall_i  = st;
    in_data  = d;
    #1;
    acc = rst_n && v && !m_drain && !st;
    stp = acc || (rst_n && m_drain && !st);
    exp_rows = '0;
    if (acc) exp_rows[0 +: W] = d[0 +: W];
    for (int k = 1; k < N; k++) begin
      if (hist.size() >= k * SKEW) begin
        old = hist[hist.size() - k * SKEW];
        exp_rows[k*W +: W] = old[k*W +: W];
      end
    end
    if (chk_en) begin
      chk_eq("in_ready", in_ready, rst_n && !m_drain && !st);
      chk_eq("stream_en", stream_en, stp);
      chk_eq("busy", busy, m_tile);
      chk_eq("tile_done", tile_done, m_done);
      chk_eq("sa_inputs", sa_inputs, exp_rows);
    end
    obs_done = tile_done;
    if (stream_en) stream_cnt++;
    if (!rst_n) begin
      hist.delete();
      m_tile  = 0;
      m_drain = 0;
      m_done  = 0;
      m_left  = 0;
    end else begin
      m_done = 0;
      if (stp) begin
        pushed = acc ? d : '0;
        hist.push_back(pushed);
        if (hist.size() > N * SKEW) void'(hist.pop_front());
      end
      if (acc) begin
        m_tile = 1;
        if (last) begin
          m_drain = 1;
          m_left  = DS;
        end
      end else if (stp && m_drain) begin
        m_left--;
        if (m_left == 0) begin
          m_drain = 0;
          m_tile  = 0;
          m_done  = 1;
        end
      end
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc(1, 0, 0, 0, '0);
      seen = obs_done;
    end
    chk_eq(tag, seen, 1'b1);
  endtask

  function automatic logic [N*W-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [N*W-1:0] va, vb, vc;

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    stall_i  = 1'b0;
    in_data  = '0;
    chk_en   = 0;
    cyc(0, 0, 0, 0, '0);
    chk_en   = 1;
    cyc(0, 1, 0, 0, rnd_vec());
    cyc(1, 0, 0, 0, '0);

    // Single vector {1.0, 2.0, 3.0, 4.0} as a whole tile.
    stream_cnt = 0;
    cyc(1, 1, 1, 0, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    wait_done("t1_done");
    chk_eq("t1_steps", stream_cnt, 1 + DS);
    cyc(1, 0, 0, 0, '0);

    // Three back-to-back vectors.
    stream_cnt = 0;
    va = rnd_vec(); vb = rnd_vec(); vc = rnd_vec();
    cyc(1, 1, 0, 0, va);
    cyc(1, 1, 0, 0, vb);
    cyc(1, 1, 1, 0, vc);
    wait_done("t2_done");
    chk_eq("t2_steps", stream_cnt, 3 + DS);

    // Same tile with a 5-cycle stall in the middle of the drain, from a fresh reset.
    cyc(0, 0, 0, 0, '0);
    stream_cnt = 0;
    cyc(1, 1, 0, 0, va);
    cyc(1, 1, 0, 0, vb);
    cyc(1, 1, 1, 0, vc);
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, rnd_vec());
    wait_done("t3_done");
    chk_eq("t3_steps", stream_cnt, 10);
`ifdef SA_SKEW_PERF_EN
    chk_eq("perf_stalls", perf_stalls, 5);
    chk_eq("perf_steps", perf_steps, 10);
`endif

    // Three-cycle in_valid gaps while streaming.
    stream_cnt = 0;
    for (int v = 0; v < 3; v++) begin
      cyc(1, 1, v == 2, 0, rnd_vec());
      if (v < 2) for (int g = 0; g < 3; g++) cyc(1, 0, 0, 0, rnd_vec());
    end
    wait_done("t4_done");
    chk_eq("t4_steps", stream_cnt, 3 + DS);

    // Reset in the middle of the drain abandons the tile.
    cyc(1, 1, 1, 0, rnd_vec());
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, '0);

    // Random traffic with stalls, gaps and occasional resets.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 150) != 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
          ($urandom % 4) == 0, rnd_vec());
    end
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
